ising_snapshot_streamer: RTL and testbench

- Consumer end of the lattice update interface: on each `update_tick` it captures spins, energy, magnetization and the update count into shadow registers.
- It then serializes them as a checksummed byte frame over a valid/ready stream toward the host link (UART/USB bridge).
- It sits beside `lattice_grid` under the top level and turns per-update lattice state into host-readable snapshots without stalling the lattice.

---
 rtl/ising_pkg.sv | 22 ++
 rtl/ising_snapshot_streamer.sv | 170 +++++++++++++++++
 tb/tb_ising_snapshot_streamer.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ising_pkg.sv
// rtl/ising_pkg.sv - shared types and constants for the lattice snapshot streamer
package ising_pkg;

    typedef enum logic [3:0] {
        IDLE,
        HDR,
        SEQ,
        E_HI,
        E_LO,
        M_HI,
        M_LO,
        SPIN,
        CSUM
    } stream_state_t;

    localparam logic [7:0] DEFAULT_HEADER_BYTE = 8'hA5;

    function automatic int frame_len(input int grid);
        return 7 + (grid * grid) / 8;
    endfunction

endpackage

// File: rtl/ising_snapshot_streamer.sv
// rtl/ising_snapshot_streamer.sv - captures lattice state on update_tick and streams it as a checksummed byte frame
module ising_snapshot_streamer
    import ising_pkg::*;
#(
    parameter int         GRID_SIZE   = 8,
    parameter logic [7:0] HEADER_BYTE = DEFAULT_HEADER_BYTE
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  update_tick,
    input  logic [GRID_SIZE-1:0][GRID_SIZE-1:0]   spin_states,
    input  logic signed [15:0]                    system_energy,
    input  logic signed [15:0]                    system_magnetization,
    input  logic [31:0]                           update_counter,
    output logic [7:0]                            m_data,
    output logic                                  m_valid,
    input  logic                                  m_ready,
    output logic                                  m_last,
    output logic                                  busy,
    output logic [15:0]                           frame_count,
    output logic [15:0]                           dropped_count
);

    localparam int NBITS = GRID_SIZE * GRID_SIZE;
    localparam int NS    = NBITS / 8;
    localparam int IDX_W = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NS - 1);

    stream_state_t    state_q, state_d;
    logic [IDX_W-1:0] spin_idx_q, spin_idx_d;
    logic [NBITS-1:0] spin_q, spin_d;
    logic [7:0]       seq_q, seq_d;
    logic [15:0]      energy_q, energy_d;
    logic [15:0]      mag_q, mag_d;
    logic [7:0]       csum_q, csum_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic [15:0]      drop_cnt_q, drop_cnt_d;

    logic             hs;
    logic             capture;
    logic [7:0]       spin_byte;

    // Only the low byte of the update counter travels in the frame.
    logic             counter_hi_unused;
    assign counter_hi_unused = ^update_counter[31:8];

    assign hs      = valid_q && m_ready;
    assign capture = update_tick && ((state_q == IDLE) || ((state_q == CSUM) && hs));

    always_comb begin
        state_d     = state_q;
        spin_idx_d  = spin_idx_q;
        spin_d      = spin_q;
        seq_d       = seq_q;
        energy_d    = energy_q;
        mag_d       = mag_q;
        csum_d      = csum_q;
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;

        if (hs) begin
            csum_d = csum_q ^ data_q;
            case (state_q)
                HDR:  state_d = SEQ;
                SEQ:  state_d = E_HI;
                E_HI: state_d = E_LO;
                E_LO: state_d = M_HI;
                M_HI: state_d = M_LO;
                M_LO: begin
                    state_d    = SPIN;
                    spin_idx_d = '0;
                end
                SPIN: begin
                    if (spin_idx_q == LAST_IDX) begin
                        state_d = CSUM;
                    end else begin
                        spin_idx_d = spin_idx_q + 1'b1;
                    end
                end
                CSUM: begin
                    state_d     = IDLE;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end
                default: state_d = IDLE;
            endcase
        end

        // A capture on the CSUM handshake overrides the return to IDLE.
        if (capture) begin
            spin_d     = spin_states;
            seq_d      = update_counter[7:0];
            energy_d   = system_energy;
            mag_d      = system_magnetization;
            csum_d     = '0;
            state_d    = HDR;
            spin_idx_d = '0;
        end else if (update_tick && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_comb begin
        spin_byte = '0;
        for (int k = 0; k < NS; k++) begin
            if (spin_idx_d == IDX_W'(k)) begin
                spin_byte = spin_d[8*k +: 8];
            end
        end
    end

    // Output byte is derived from next-state values so it is registered and
    // cannot change while a presented byte waits for m_ready.
    always_comb begin
        data_d = '0;
        case (state_d)
            HDR:     data_d = HEADER_BYTE;
            SEQ:     data_d = seq_d;
            E_HI:    data_d = energy_d[15:8];
            E_LO:    data_d = energy_d[7:0];
            M_HI:    data_d = mag_d[15:8];
            M_LO:    data_d = mag_d[7:0];
            SPIN:    data_d = spin_byte;
            CSUM:    data_d = csum_d;
            default: data_d = '0;
        endcase
        valid_d = (state_d != IDLE);
        last_d  = (state_d == CSUM);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            spin_idx_q  <= '0;
            spin_q      <= '0;
            seq_q       <= '0;
            energy_q    <= '0;
            mag_q       <= '0;
            csum_q      <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            spin_idx_q  <= spin_idx_d;
            spin_q      <= spin_d;
            seq_q       <= seq_d;
            energy_q    <= energy_d;
            mag_q       <= mag_d;
            csum_q      <= csum_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign m_data        = data_q;
    assign m_valid       = valid_q;
    assign m_last        = last_q;
    assign busy          = (state_q != IDLE);
    assign frame_count   = frame_cnt_q;
    assign dropped_count = drop_cnt_q;

endmodule

// File: tb/tb_ising_snapshot_streamer.sv
// tb/tb_ising_snapshot_streamer.sv - directed self-checking bench for ising_snapshot_streamer
module tb_ising_snapshot_streamer;

    logic              clk = 1'b0;
    logic              rst;
    logic              update_tick;
    logic [7:0][7:0]   spin_states;
    logic signed [15:0] system_energy;
    logic signed [15:0] system_magnetization;
    logic [31:0]       update_counter;
    logic [7:0]        m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;
    logic              busy;
    logic [15:0]       frame_count;
    logic [15:0]       dropped_count;

    always #5 clk = ~clk;

    ising_snapshot_streamer dut (
        .clk                  (clk),
        .rst                  (rst),
        .update_tick          (update_tick),
        .spin_states          (spin_states),
        .system_energy        (system_energy),
        .system_magnetization (system_magnetization),
        .update_counter       (update_counter),
        .m_data               (m_data),
        .m_valid              (m_valid),
        .m_ready              (m_ready),
        .m_last               (m_last),
        .busy                 (busy),
        .frame_count          (frame_count),
        .dropped_count        (dropped_count)
    );

    int         errors = 0;
    int         checks = 0;
    logic [7:0] got [0:31];
    logic       got_last [0:31];
    int         got_n;
    int         stable_err;
    logic [7:0] exp_b [0:14];
    logic [15:0] exp_frames = 16'd0;

    task automatic build_exp(input logic [7:0][7:0] sp, input logic [15:0] e,
                             input logic [15:0] m, input logic [31:0] cnt);
        logic [7:0] x;
        exp_b[0] = 8'hA5;
        exp_b[1] = cnt[7:0];
        exp_b[2] = e[15:8];
        exp_b[3] = e[7:0];
        exp_b[4] = m[15:8];
        exp_b[5] = m[7:0];
        for (int k = 0; k < 8; k++) begin
            for (int b = 0; b < 8; b++) begin
                exp_b[6+k][b] = sp[(8*k+b)/8][(8*k+b)%8];
            end
        end
        x = 8'h00;
        for (int i = 0; i < 14; i++) x = x ^ exp_b[i];
        exp_b[14] = x;
    endtask

    task automatic start_frame(input logic [7:0][7:0] sp, input logic [15:0] e,
                               input logic [15:0] m, input logic [31:0] cnt);
        spin_states          = sp;
        system_energy        = e;
        system_magnetization = m;
        update_counter       = cnt;
        update_tick          = 1'b1;
        @(negedge clk);
        update_tick          = 1'b0;
    endtask

    // Collects one frame; tmask bit c pulses update_tick in frame cycle c.
    task automatic run_frame(input bit rnd, input logic [31:0] tmask);
        bit         done;
        logic       pstall;
        logic [7:0] pdata;
        logic       plast;
        int         c;
        got_n = 0; stable_err = 0; done = 0; pstall = 0; pdata = '0; plast = 0; c = 0;
        while (!done && c < 400) begin
            update_tick = (c < 32) ? tmask[c] : 1'b0;
            m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pstall && (!m_valid || m_data !== pdata || m_last !== plast)) stable_err++;
            if (m_valid && m_ready) begin
                got[got_n] = m_data;
                got_last[got_n] = m_last;
                if (got_n < 31) got_n++;
                if (m_last) done = 1;
            end
            pstall = m_valid && !m_ready;
            pdata = m_data;
            plast = m_last;
            @(negedge clk);
            c++;
        end
        update_tick = 1'b0;
        m_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; update_tick = 1'b0; m_ready = 1'b0;
        spin_states = '0; system_energy = '0; system_magnetization = '0; update_counter = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (m_valid !== 1'b0 || m_data !== 8'h00 || m_last !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs valid=%b data=%h last=%b busy=%b required 0 00 0 0",
                     m_valid, m_data, m_last, busy);
        end
        checks++;
        if (frame_count !== 16'd0 || dropped_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_counters frames=%0d dropped=%0d required 0 0", frame_count, dropped_count);
        end
        rst = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] hand [0:14] = '{8'hA5, 8'h03, 8'hFF, 8'h80, 8'h00, 8'h40,
                                    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h99};
        start_frame('0, 16'hFF80, 16'h0040, 32'h0000_0103);
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'hA5 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_first_byte valid=%b data=%h busy=%b required 1 a5 1", m_valid, m_data, busy);
        end
        run_frame(0, 32'h0);
        exp_frames++;
        checks++;
        if (got_n !== 15) begin
            errors++;
            $display("FAIL basic_len got=%0d required 15", got_n);
        end
        for (int i = 0; i < 15; i++) begin
            checks++;
            if (got[i] !== hand[i] || got_last[i] !== (i == 14)) begin
                errors++;
                $display("FAIL basic_byte%0d got=%h last=%b required %h last=%b",
                         i, got[i], got_last[i], hand[i], (i == 14));
            end
        end
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || frame_count !== 16'd1) begin
            errors++;
            $display("FAIL basic_after valid=%b busy=%b frames=%0d required 0 0 1", m_valid, busy, frame_count);
        end
    endtask

    task automatic test_diagonal();
        logic [7:0][7:0] sp;
        logic [7:0] hand [0:14] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                                    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h5A};
        for (int r = 0; r < 8; r++) sp[r] = 8'h01 << r;
        start_frame(sp, 16'h0000, 16'h0000, 32'h1234_5600);
        run_frame(0, 32'h0);
        exp_frames++;
        checks++;
        if (got_n !== 15) begin
            errors++;
            $display("FAIL diag_len got=%0d required 15", got_n);
        end
        for (int i = 0; i < 15; i++) begin
            checks++;
            if (got[i] !== hand[i]) begin
                errors++;
                $display("FAIL diag_byte%0d got=%h required %h", i, got[i], hand[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        build_exp('0, 16'hFF80, 16'h0040, 32'h0000_0103);
        start_frame('0, 16'hFF80, 16'h0040, 32'h0000_0103);
        run_frame(1, 32'h0);
        exp_frames++;
        checks++;
        if (stable_err !== 0) begin
            errors++;
            $display("FAIL bp_stable unstable_cycles=%0d required 0", stable_err);
        end
        checks++;
        if (got_n !== 15) begin
            errors++;
            $display("FAIL bp_len got=%0d required 15", got_n);
        end
        for (int i = 0; i < 15; i++) begin
            checks++;
            if (got[i] !== exp_b[i] || got_last[i] !== (i == 14)) begin
                errors++;
                $display("FAIL bp_byte%0d got=%h last=%b required %h last=%b",
                         i, got[i], got_last[i], exp_b[i], (i == 14));
            end
        end
        checks++;
        if (frame_count !== exp_frames) begin
            errors++;
            $display("FAIL bp_frames got=%0d required %0d", frame_count, exp_frames);
        end
    endtask

    task automatic test_drops();
        logic [7:0][7:0] sp;
        for (int r = 0; r < 8; r++) sp[r] = 8'h11 * (r + 1);
        build_exp(sp, 16'h8001, 16'hFFFE, 32'hABCD_EF5C);
        start_frame(sp, 16'h8001, 16'hFFFE, 32'hABCD_EF5C);
        spin_states = '1; system_energy = 16'h1111; system_magnetization = 16'h2222; update_counter = 32'h77;
        run_frame(0, (32'h1 << 2) | (32'h1 << 4) | (32'h1 << 8));
        exp_frames++;
        checks++;
        if (dropped_count !== 16'd3) begin
            errors++;
            $display("FAIL drop_count got=%0d required 3", dropped_count);
        end
        checks++;
        if (got_n !== 15) begin
            errors++;
            $display("FAIL drop_len got=%0d required 15", got_n);
        end
        for (int i = 0; i < 15; i++) begin
            checks++;
            if (got[i] !== exp_b[i]) begin
                errors++;
                $display("FAIL drop_byte%0d got=%h required %h", i, got[i], exp_b[i]);
            end
        end
        checks++;
        if (busy !== 1'b0 || frame_count !== exp_frames) begin
            errors++;
            $display("FAIL drop_after busy=%b frames=%0d required 0 %0d", busy, frame_count, exp_frames);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0][7:0] sp_b;
        for (int r = 0; r < 8; r++) sp_b[r] = 8'hC3 ^ 8'(r);
        build_exp('0, 16'h0102, 16'h0304, 32'h0000_0010);
        start_frame('0, 16'h0102, 16'h0304, 32'h0000_0010);
        spin_states = sp_b; system_energy = 16'hF00F; system_magnetization = 16'h0FF0; update_counter = 32'h0000_01C7;
        run_frame(0, 32'h1 << 14);
        exp_frames++;
        checks++;
        if (got_n !== 15 || got[14] !== exp_b[14]) begin
            errors++;
            $display("FAIL b2b_first_frame len=%0d csum=%h required 15 %h", got_n, got[14], exp_b[14]);
        end
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'hA5 || m_last !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_gap valid=%b data=%h last=%b required 1 a5 0", m_valid, m_data, m_last);
        end
        checks++;
        if (frame_count !== exp_frames || dropped_count !== 16'd3) begin
            errors++;
            $display("FAIL b2b_counts frames=%0d dropped=%0d required %0d 3", frame_count, dropped_count, exp_frames);
        end
        build_exp(sp_b, 16'hF00F, 16'h0FF0, 32'h0000_01C7);
        run_frame(0, 32'h0);
        exp_frames++;
        checks++;
        if (got_n !== 15) begin
            errors++;
            $display("FAIL b2b_len got=%0d required 15", got_n);
        end
        for (int i = 0; i < 15; i++) begin
            checks++;
            if (got[i] !== exp_b[i]) begin
                errors++;
                $display("FAIL b2b_byte%0d got=%h required %h", i, got[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0][7:0] sp;
        for (int r = 0; r < 8; r++) sp[r] = 8'h5A >> (r % 4);
        build_exp(sp, 16'h7FFF, 16'h8000, 32'h0000_0042);
        start_frame(sp, 16'h7FFF, 16'h8000, 32'h0000_0042);
        m_ready = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if (m_valid !== 1'b1 || m_data !== exp_b[8] || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_spin valid=%b data=%h busy=%b required 1 %h 1", m_valid, m_data, busy, exp_b[8]);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || m_last !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_outputs valid=%b busy=%b last=%b required 0 0 0", m_valid, busy, m_last);
        end
        checks++;
        if (frame_count !== 16'd0 || dropped_count !== 16'd0) begin
            errors++;
            $display("FAIL mid_rst_counters frames=%0d dropped=%0d required 0 0", frame_count, dropped_count);
        end
        rst = 1'b0;
        @(negedge clk);
        build_exp(sp, 16'h1234, 16'hFEDC, 32'h0000_0099);
        start_frame(sp, 16'h1234, 16'hFEDC, 32'h0000_0099);
        run_frame(0, 32'h0);
        checks++;
        if (got_n !== 15) begin
            errors++;
            $display("FAIL post_rst_len got=%0d required 15", got_n);
        end
        for (int i = 0; i < 15; i++) begin
            checks++;
            if (got[i] !== exp_b[i] || got_last[i] !== (i == 14)) begin
                errors++;
                $display("FAIL post_rst_byte%0d got=%h last=%b required %h last=%b",
                         i, got[i], got_last[i], exp_b[i], (i == 14));
            end
        end
        checks++;
        if (frame_count !== 16'd1) begin
            errors++;
            $display("FAIL post_rst_frames got=%0d required 1", frame_count);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_diagonal();
        test_backpressure();
        test_drops();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
